// File: rtl/dec_scan_pkg.sv
// Shared types and helpers for the dec_scan registered/scanning line decoder.
package dec_scan_pkg;

    localparam int unsigned MAX_SEL_W = 6;
    localparam int unsigned MAX_LINES = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_BLANK  = 2'd3
    } state_e;

    // Active-low one-hot of index; all ones when index is not below n.
    function automatic logic [MAX_LINES-1:0] onehot_n(input logic [MAX_SEL_W-1:0] index,
                                                      input int unsigned n);
        logic [MAX_LINES-1:0] v;
        v = '1;
        if (32'(index) < n) begin
            v[index] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/dec_scan_tick.sv
// Scan prescaler: counts 0..PRESCALE-1 and flags the last count as the step cycle.
module dec_scan_tick #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PRE_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    output logic [PRE_W-1:0] pre_o,
    output logic             tick_c
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign tick_c = (pre_q == PRE_W'(PRESCALE - 1));
    assign pre_o  = pre_q;

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        if (clr_i || tick_c) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/dec_scan.sv
// Registered N-to-M active-low decoder with a self-timed scan mode.
// Optional DEC_SCAN_BLANK_EN blanks the final prescaler cycle of each scan step.
module dec_scan
    import dec_scan_pkg::*;
#(
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned OUT_N    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_N-1:0] y_n,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned BLANK_AT = (PRESCALE > 1) ? PRESCALE - 2 : 0;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [OUT_N-1:0] y_n_q, y_n_d;
    logic             wrap_q, wrap_d;

    logic             in_scan_c;
    logic             clr_c;
    logic             tick_c;
    logic             blank_c;
    logic             last_c;
    logic [SEL_W-1:0] cnt_inc_c;
    logic [PRE_W-1:0] pre_cnt;

    assign in_scan_c = (state_q == ST_SCAN) || (state_q == ST_BLANK);
    // Prescaler runs only while a scan continues; any entry or exit restarts it.
    assign clr_c     = !(en && mode && in_scan_c);
    assign last_c    = (cnt_q == SEL_W'(OUT_N - 1));
    assign cnt_inc_c = last_c ? '0 : cnt_q + SEL_W'(1);

`ifdef DEC_SCAN_BLANK_EN
    assign blank_c = (PRESCALE > 1) && in_scan_c && (pre_cnt == PRE_W'(BLANK_AT));
`else
    logic unused_pre;
    assign unused_pre = ^pre_cnt;
    assign blank_c    = 1'b0;
`endif

    dec_scan_tick #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_c),
        .pre_o  (pre_cnt),
        .tick_c (tick_c)
    );

    // Next state and next registered outputs, re-evaluated every cycle.
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        y_n_d   = '1;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (!mode) begin
            state_d = ST_DIRECT;
            idx_d   = sel;
            y_n_d   = OUT_N'(onehot_n(MAX_SEL_W'(sel), OUT_N));
        end else if (!in_scan_c) begin
            state_d = ST_SCAN;
            y_n_d   = OUT_N'(onehot_n('0, OUT_N));
        end else if (blank_c) begin
            state_d = ST_BLANK;
            cnt_d   = cnt_q;
            idx_d   = cnt_q;
        end else begin
            state_d = ST_SCAN;
            cnt_d   = tick_c ? cnt_inc_c : cnt_q;
            idx_d   = cnt_d;
            y_n_d   = OUT_N'(onehot_n(MAX_SEL_W'(cnt_d), OUT_N));
            wrap_d  = tick_c && last_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            y_n_q   <= '1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            y_n_q   <= y_n_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y_n  = y_n_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed self-checking bench for dec_scan (4 lines / PRESCALE 3, plus 3 lines / PRESCALE 1).
module tb_dec_scan;

    logic       clk;
    logic       rst;
    logic       en, mode;
    logic [1:0] sel;
    logic [3:0] y_n;
    logic [1:0] idx;
    logic       wrap;

    logic       en3, mode3;
    logic [1:0] sel3;
    logic [2:0] y_n3;
    logic [1:0] idx3;
    logic       wrap3;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0] exp3_y [4];

    dec_scan #(.SEL_W(2), .OUT_N(4), .PRESCALE(3)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .y_n(y_n), .idx(idx), .wrap(wrap)
    );

    dec_scan #(.SEL_W(2), .OUT_N(3), .PRESCALE(1)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .mode(mode3), .sel(sel3),
        .y_n(y_n3), .idx(idx3), .wrap(wrap3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Expected 4-line / PRESCALE 3 scan output, step 0 being the entry cycle.
    function automatic logic [3:0] exp_y(input int step);
        int         i;
        logic [3:0] v;
        i = step % 12;
        v = 4'hF;
`ifdef DEC_SCAN_BLANK_EN
        if ((i % 3) == 2) return v;
`endif
        v[i / 3] = 1'b0;
        return v;
    endfunction

    function automatic logic [1:0] exp_idx(input int step);
        return 2'((step % 12) / 3);
    endfunction

    function automatic logic exp_wrap(input int step);
        return (step > 0) && ((step % 12) == 0);
    endfunction

    task automatic scan_check(input string tag, input int step);
        check({tag, "_y"}, 32'(y_n), 32'(exp_y(step)));
        check({tag, "_idx"}, 32'(idx), 32'(exp_idx(step)));
        check({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap(step)));
    endtask

    initial begin
        exp3_y[0] = 3'b110;
        exp3_y[1] = 3'b101;
        exp3_y[2] = 3'b011;
        exp3_y[3] = 3'b110;

        rst = 1'b0; en = 1'b1; mode = 1'b0; sel = 2'd2;
        en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd3;
        #1 rst = 1'b1;

        // Held in reset across clock edges despite enabled direct inputs
        cyc();
        check("rst_y", 32'(y_n), 32'h0000_000F);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_y3", 32'(y_n3), 32'h7);
        rst = 1'b0;

        cyc();
        check("dir_sel2_y", 32'(y_n), 32'b1011);
        check("dir_sel2_idx", 32'(idx), 32'd2);
        check("dir3_sel3_y", 32'(y_n3), 32'b111);
        check("dir3_sel3_idx", 32'(idx3), 32'd3);
        sel = 2'd0;
        sel3 = 2'd2;

        cyc();
        check("dir_sel0_y", 32'(y_n), 32'b1110);
        check("dir_sel0_idx", 32'(idx), 32'd0);
        check("dir3_sel2_y", 32'(y_n3), 32'b011);
        en = 1'b0; sel = 2'd1;

        cyc();
        check("idle_y", 32'(y_n), 32'hF);
        check("idle_idx", 32'(idx), 32'd0);
        check("idle_wrap", 32'(wrap), 32'd0);

        // Scan from IDLE (4 lines) and from DIRECT (3 lines, PRESCALE 1)
        en = 1'b1; mode = 1'b1; mode3 = 1'b1;
        for (int s = 0; s <= 18; s++) begin
            cyc();
            scan_check("scan", s);
            if (s < 4) begin
                check("scan3_y", 32'(y_n3), 32'(exp3_y[s]));
                check("scan3_wrap", 32'(wrap3), 32'(s == 3));
            end
        end

        // Step 18 is index 2: drop to direct, then re-enter scan
        mode = 1'b0; sel = 2'd1;
        cyc();
        check("sw_dir_y", 32'(y_n), 32'b1101);
        check("sw_dir_idx", 32'(idx), 32'd1);
        check("sw_dir_wrap", 32'(wrap), 32'd0);
        mode = 1'b1;
        for (int s = 0; s <= 9; s++) begin
            cyc();
            scan_check("rescan", s);
        end

        // Step 9 is index 3: asynchronous reset between edges
        #1 rst = 1'b1;
        #1;
        check("async_rst_y", 32'(y_n), 32'hF);
        check("async_rst_idx", 32'(idx), 32'd0);
        check("async_rst_wrap", 32'(wrap), 32'd0);
        cyc();
        rst = 1'b0;
        for (int s = 0; s <= 12; s++) begin
            cyc();
            scan_check("post_rst", s);
        end

        // Random toggling: never more than one line low
        for (int c = 0; c < 10000; c++) begin
            en    = 1'($urandom_range(0, 3) != 0);
            mode  = 1'($urandom_range(0, 1));
            sel   = 2'($urandom_range(0, 3));
            en3   = 1'($urandom_range(0, 3) != 0);
            mode3 = 1'($urandom_range(0, 1));
            sel3  = 2'($urandom_range(0, 3));
            cyc();
            check("onehot4", 32'($countones(~y_n) <= 1), 32'd1);
            check("onehot3", 32'($countones(~y_n3) <= 1), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dec_scan.md
# dec_scan

Parametrised, registered N-to-M line decoder with active-high enable and active-low one-hot outputs. It is the next generation of the team's 2-to-4 enable decoder. It adds a clocked output stage and a self-timed scan mode: an internal prescaled counter walks the active line across all outputs. Typical use is digit/row select for multiplexed display and keypad logic.

## Interface
Parameters:
- SEL_W, default 2: select width; legal 1..6.
- OUT_N, default 4: number of output lines; legal 2..2**SEL_W.
- PRESCALE, default 4: clock cycles per scan step; legal ≥1.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: active-high enable.
- mode, input, 1: 0 = direct decode of sel; 1 = scan.
- sel, input, SEL_W: line index used in direct mode.
- y_n, output, OUT_N: active-low one-hot select lines.
- idx, output, SEL_W: index of the currently driven line; the value it holds while blanked or idle is defined under Operation.
- wrap, output, 1: one-cycle pulse when the scan returns from OUT_N-1 to 0.

## Operation
- States are IDLE, DIRECT, SCAN, and BLANK (BLANK exists only with the macro). The state is re-evaluated every cycle from en and mode.
- IDLE (en=0):
  - y_n = all ones, idx = 0, wrap = 0.
  - The prescaler and the scan counter are cleared.
- DIRECT (en=1, mode=0):
  - y_n[sel] is driven low; all other bits are high.
  - If sel ≥ OUT_N, y_n is all ones.
  - idx = sel, wrap = 0.
  - The scan counter is held at 0.
- SCAN (en=1, mode=1):
  - The prescaler counts 0..PRESCALE-1.
  - On the cycle where the prescaler equals PRESCALE-1, the scan counter advances: k → k+1, or OUT_N-1 → 0.
  - y_n[k] is low and idx = k.
  - wrap is asserted in the same registered cycle in which the outputs first show index 0 after index OUT_N-1. It is not asserted on scan entry.
- Mode change DIRECT→SCAN, or IDLE→SCAN: the scan starts at index 0 with the prescaler cleared. Index 0 is held for exactly PRESCALE cycles.
- Mode change SCAN→DIRECT: the next output cycle reflects sel. The scan counter is cleared.
- Width rules:
  - The prescaler is $clog2(PRESCALE) bits wide, minimum 1.
  - The scan counter is SEL_W bits wide.
  - Index comparisons are unsigned.
  - No line at or above OUT_N is ever driven low.
- Reset mid-scan: y_n goes all ones and idx and wrap go to 0 immediately and asynchronously. After reset release, a held mode=1 restarts at index 0.

## Timing
- Reset values: y_n = {OUT_N{1'b1}}, idx = 0, wrap = 0, prescaler = 0, state = IDLE.
- All outputs are registered, with no combinational path from inputs to outputs.
- Direct mode latency is 1 cycle, sel/en → y_n.
- In scan mode each line is low for exactly PRESCALE cycles (PRESCALE-1 cycles with the macro).
- A full scan period is OUT_N·PRESCALE cycles.
- With PRESCALE=1, the scan advances every cycle.
- At most one y_n bit is low in any cycle under all conditions, including mode and en changes.

## Configuration
- DEC_SCAN_BLANK_EN defined:
  - The final prescaler cycle of each scan step is a BLANK cycle: y_n is all ones, idx holds the outgoing index, wrap = 0.
  - This suppresses display ghosting.
  - With PRESCALE=1, BLANK is skipped; there is no blanking.
- DEC_SCAN_BLANK_EN undefined:
  - There is no BLANK state.
  - Consecutive lines hand over directly, edge to edge.
- Direct mode is identical in both builds.

## Structure
- A shared package, dec_scan_pkg, holds:
  - The state enum: ST_IDLE, ST_DIRECT, ST_SCAN, ST_BLANK.
  - A function onehot_n(index, n), which returns the active-low one-hot vector and all ones when index ≥ n.
- One sub-module, dec_scan_tick, is natural: the prescaler producing a one-cycle step pulse, with a synchronous clear input.
- The top level holds the FSM, the scan counter and the output registers.

## Test plan
All scenarios use SEL_W=2, OUT_N=4, PRESCALE=3 unless noted.
- Reset and direct decode: assert rst, then release with en=1, mode=0, sel=2. Required: y_n=4'b1111 during reset, then 4'b1011 one cycle after release; sel=0 → 4'b1110 on the next cycle.
- Enable low: en=0 with any sel → y_n=4'b1111, idx=0. With OUT_N=3 and sel=3 → y_n=3'b111.
- Scan sequence: en=1, mode=1.
  - y_n sequence is 1110×3, 1101×3, 1011×3, 0111×3, then 1110.
  - wrap is high only in the first 1110 cycle after 0111.
  - With DEC_SCAN_BLANK_EN, each group is 2 active cycles plus 1 cycle of 1111.
- Mode switch: mid-scan at index 2, set mode=0, sel=1 → the next cycle y_n=1101. Setting mode=1 again → the scan restarts at 1110 for 3 cycles.
- Reset mid-scan: assert rst asynchronously between clock edges at index 3 → y_n=1111 before the next edge. After release with mode=1 → the scan restarts at index 0 with no wrap pulse.
- One-hot invariant: randomised en/mode/sel toggling for 10k cycles → at most one zero in y_n every cycle.
